// File: rtl/md_seq_pkg.sv
// md_pkg: shared definitions for the MIPS multiply/divide sequencer.
//   - op_ctr encodings (MD_MUL .. MD_MTLO); 3'b110/3'b111 are no-ops
//   - md_state_t: sequencer FSM states (IDLE, MUL, DIV)
//   - DIV_CYCLES: busy cycles of one divide (32 iterations + 1 sign fix)
//   - md_product(): 64-bit product, signed or unsigned
package md_pkg;

  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_MULU = 3'b001;
  localparam logic [2:0] MD_DIV  = 3'b010;
  localparam logic [2:0] MD_DIVU = 3'b011;
  localparam logic [2:0] MD_MTHI = 3'b100;
  localparam logic [2:0] MD_MTLO = 3'b101;

  localparam int DIV_CYCLES = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_t;

  // Extending both operands to 64 bits and keeping the low 64 bits of the
  // product gives the correct two's-complement result for the signed case.
  function automatic logic [63:0] md_product(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    eb = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/md_seq_if.sv
// md_seq_if: EX-stage <-> multiply/divide sequencer bundle.
//   master (EX side) drives : op_valid, op_ctr, op_a, op_b, rd_req, rd_sel, flush
//   slave (sequencer) drives: op_ready, rd_data, stall, busy, hi, lo, state
// Handshake: an operation transfers on a rising edge where op_valid and
// op_ready are both high; op_ctr/op_a/op_b must be stable while op_valid is
// high, and op_ready never depends on op_valid.
interface md_seq_if;
  import md_pkg::*;

  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_ctr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  md_state_t   state;   // debug view of the sequencer FSM

  modport master (
    output op_valid, op_ctr, op_a, op_b, rd_req, rd_sel, flush,
    input  op_ready, rd_data, stall, busy, hi, lo, state
  );

  modport slave (
    input  op_valid, op_ctr, op_a, op_b, rd_req, rd_sel, flush,
    output op_ready, rd_data, stall, busy, hi, lo, state
  );

endinterface

// File: rtl/md_seq_div.sv
// md_div_iter: iterative radix-2 restoring divider.
//   i_start  : load operands (magnitudes are taken here) and begin
//   i_signed : treat i_a/i_b as two's complement (div) instead of unsigned
//   i_abort  : drop the running divide
//   o_done   : high for the one cycle in which o_quot/o_rem are final
//   o_dbz    : divisor of the current/last divide was zero
// Timing: start edge, then 32 iteration edges; o_done is high in the next
// cycle, where the sign fix is applied combinationally to the results.
module md_div_iter
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_abort,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic        o_dbz,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  localparam int ITERS = DIV_CYCLES - 1;

  logic        r_run;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;   // dividend bits shift out the top, quotient bits in
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dbz;

  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_ge;

  assign w_a_mag = (i_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_b_mag = (i_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;

  // Partial remainder stays below 2*divisor, so 33 bits suffice and the
  // borrow bit of the difference is the restore decision.
  assign w_trial = {r_rem, r_quo[31]};
  assign w_diff  = w_trial - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[32];

  assign o_done = r_run && (r_cnt == 6'(ITERS));
  assign o_dbz  = r_dbz;
  assign o_quot = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign o_rem  = r_neg_r ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_cnt   <= 6'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (i_abort) begin
      r_run <= 1'b0;
      r_cnt <= 6'd0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_cnt   <= 6'd0;
      r_rem   <= 32'd0;
      r_quo   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_neg_q <= i_signed && (i_a[31] ^ i_b[31]);
      r_neg_r <= i_signed && i_a[31];
      r_dbz   <= (i_b == 32'd0);
    end else if (r_run) begin
      if (r_cnt == 6'(ITERS)) begin
        r_run <= 1'b0;
        r_cnt <= 6'd0;
      end else begin
        r_rem <= w_ge ? w_diff[31:0] : w_trial[31:0];
        r_quo <= {r_quo[30:0], w_ge};
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/md_seq.sv
// md_seq: multi-cycle multiply/divide sequencer owning the MIPS HI/LO pair.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : md_seq_if.slave (operation handshake, mfhi/mflo read port,
//              flush, busy/stall status, HI/LO and FSM state views)
//   MUL_LAT  : cycles a mult/multu spends in MUL (>= 1)
// Build option MD_FAST_MUL_EN: when defined, mult/multu commit HI/LO on the
// accept edge like mthi/mtlo, and the MUL state/counter are compiled out.
// Reads are never forwarded: the committed value shows on rd_data in the
// first cycle with busy low.
module md_seq
  import md_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input logic   clk,
  input logic   rst,
  md_seq_if.slave bus
);

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        w_hi_we;
  logic        w_lo_we;
  logic        w_accept;
  logic        w_div_start;
  logic        w_div_done;
  logic        w_div_dbz;
  logic [31:0] w_div_quot;
  logic [31:0] w_div_rem;
  logic [63:0] w_prod;

`ifdef MD_FAST_MUL_EN
  assign w_prod = md_product(bus.op_a, bus.op_b, bus.op_ctr == MD_MUL);
`else
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_ma;
  logic [31:0]      r_mb;
  logic             r_msigned;
  logic             w_mul_load;

  assign w_prod = md_product(r_ma, r_mb, r_msigned);
`endif

  assign bus.op_ready = (r_state == IDLE) && !bus.flush;
  assign bus.busy     = (r_state != IDLE);
  assign bus.stall    = bus.rd_req && bus.busy;
  assign bus.rd_data  = bus.rd_sel ? r_hi : r_lo;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.state    = r_state;

  assign w_accept = bus.op_valid && bus.op_ready;

  md_div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_div_start),
    .i_signed (bus.op_ctr == MD_DIV),
    .i_abort  (bus.flush),
    .i_a      (bus.op_a),
    .i_b      (bus.op_b),
    .o_done   (w_div_done),
    .o_dbz    (w_div_dbz),
    .o_quot   (w_div_quot),
    .o_rem    (w_div_rem)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_div_start = 1'b0;
`ifndef MD_FAST_MUL_EN
    w_mul_load  = 1'b0;
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (bus.op_ctr)
            MD_MUL, MD_MULU: begin
`ifdef MD_FAST_MUL_EN
              w_hi_we  = 1'b1;
              w_lo_we  = 1'b1;
              w_hi_nxt = w_prod[63:32];
              w_lo_nxt = w_prod[31:0];
`else
              w_mul_load  = 1'b1;
              w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
              w_state_nxt = MUL;
`endif
            end
            MD_DIV, MD_DIVU: begin
              w_div_start = 1'b1;
              w_state_nxt = DIV;
            end
            MD_MTHI: begin
              w_hi_we  = 1'b1;
              w_hi_nxt = bus.op_a;
            end
            MD_MTLO: begin
              w_lo_we  = 1'b1;
              w_lo_nxt = bus.op_a;
            end
            default: ;  // 110/111 are accepted and ignored
          endcase
        end
      end
      MUL: begin
`ifdef MD_FAST_MUL_EN
        w_state_nxt = IDLE;
`else
        // flush takes priority over a completion in the same cycle
        if (bus.flush) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_hi_we     = 1'b1;
          w_lo_we     = 1'b1;
          w_hi_nxt    = w_prod[63:32];
          w_lo_nxt    = w_prod[31:0];
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`endif
      end
      DIV: begin
        if (bus.flush) begin
          w_state_nxt = IDLE;
        end else if (w_div_done) begin
          // divide by zero runs the full length but leaves HI/LO alone
          w_hi_we     = !w_div_dbz;
          w_lo_we     = !w_div_dbz;
          w_hi_nxt    = w_div_rem;
          w_lo_nxt    = w_div_quot;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_nxt;
      if (w_lo_we) r_lo <= w_lo_nxt;
    end
  end

`ifndef MD_FAST_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ma      <= 32'd0;
      r_mb      <= 32'd0;
      r_msigned <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_mul_load) begin
        r_ma      <= bus.op_a;
        r_mb      <= bus.op_b;
        r_msigned <= (bus.op_ctr == MD_MUL);
      end
    end
  end
`endif

endmodule

// File: tb/tb_md_seq.sv
// Bench for md_seq: directed cases plus randomized operations. The driver
// pushes {expected HI, expected LO, expected busy length} at each accept;
// the monitor pops on every commit (busy falling, or the cycle after a
// zero-latency accept) and compares.
module tb_md_seq;
  import md_pkg::*;

  localparam int MUL_LAT = 3;
`ifdef MD_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = MUL_LAT;
`endif
  localparam int W = 72;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_seq_if bus();

  md_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural effect of one op, straight arithmetic.
  task automatic model_op(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    int ia, ib, len;
    len = 0;
    ia = $signed(a);
    ib = $signed(b);
    sa = ia;
    sb = ib;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (ctr)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; len = MUL_BUSY; end
      3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; len = MUL_BUSY; end
      3'd2: begin
        len = DIV_CYCLES;
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      3'd3: begin
        len = DIV_CYCLES;
        if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
    exp_q.push_back({m_hi, m_lo, 8'(len)});
  endtask

  function automatic bit zero_lat(input logic [2:0] ctr);
`ifdef MD_FAST_MUL_EN
    return (ctr >= 3'd4) || (ctr <= 3'd1);
`else
    return (ctr >= 3'd4);
`endif
  endfunction

  // ---------------- monitor ----------------
  int run_len = 0;
  bit prev_busy = 1'b0;
  bit pend_zero = 1'b0;
  logic [W-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      check32("stall", 32'(bus.stall), 32'(bus.rd_req && bus.busy));
      check32("op_ready", 32'(bus.op_ready), 32'(!bus.busy && !bus.flush));
    end
    if (pend_zero || (prev_busy && !bus.busy)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: hi=%h lo=%h at %0t", bus.hi, bus.lo, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check32("hi", bus.hi, mon_e[71:40]);
        check32("lo", bus.lo, mon_e[39:8]);
        check32("busy_len", 32'(run_len), 32'(mon_e[7:0]));
        check32("rd_data", bus.rd_data, bus.rd_sel ? mon_e[71:40] : mon_e[39:8]);
      end
      pend_zero = 1'b0;
    end
    if (bus.busy) run_len = (prev_busy ? run_len : 0) + 1;
    else run_len = 0;
    if (!rst && bus.op_valid && bus.op_ready && zero_lat(bus.op_ctr)) pend_zero = 1'b1;
    prev_busy = bus.busy;
  end

  // ---------------- driver tasks (called/return at posedge+#1) ----------------
  task automatic issue(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b,
                       input bit do_model);
    int n;
    n = 0;
    bus.op_valid = 1'b1;
    bus.op_ctr   = ctr;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    while (!bus.op_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.op_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op_ready=%b required=1", bus.op_ready);
    end else if (do_model) begin
      model_op(ctr, a, b);
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check32("idle_timeout", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [2:0]  ctr;
    logic [31:0] a, b;
    bus.op_valid = 1'b0;
    bus.op_ctr   = 3'd0;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    bus.rd_req   = 1'b1;
    bus.rd_sel   = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check32("rst_hi", bus.hi, 32'd0);
    check32("rst_lo", bus.lo, 32'd0);
    check32("rst_busy", 32'(bus.busy), 32'd0);
    check32("rst_stall", 32'(bus.stall), 32'd0);
    check32("rst_ready", 32'(bus.op_ready), 32'd1);
    check32("rst_state", 32'(bus.state), 32'(IDLE));
    @(posedge clk);
    #1 bus.rd_req = 1'b0;

    // multiplies
    issue(MD_MUL, 32'hFFFFFFFF, 32'd2, 1'b1);  wait_idle();
    issue(MD_MULU, 32'hFFFFFFFF, 32'd2, 1'b1); wait_idle();

    // divides
    issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);  wait_idle();
    issue(MD_DIVU, 32'd7, 32'd2, 1'b1);        wait_idle();
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1); wait_idle();

    // mfhi during a divide stalls for the whole divide
    issue(MD_DIVU, 32'd100, 32'd7, 1'b1);
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check32("stall_cycles", 32'(n), 32'(DIV_CYCLES));
    check32("rd_after_stall", bus.rd_data, 32'd2);
    @(posedge clk);
    #1 bus.rd_req = 1'b0;

    // divide by zero leaves HI/LO alone
    issue(MD_MTHI, 32'd5, 32'd0, 1'b1);
    issue(MD_DIV, 32'd9, 32'd0, 1'b1);
    wait_idle();
    check32("dbz_hi", bus.hi, 32'd5);

    // flush in cycle 10 of a divide
    issue(MD_DIV, 32'd1000, 32'd3, 1'b0);
    exp_q.push_back({m_hi, m_lo, 8'd10});
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check32("flush_busy", 32'(bus.busy), 32'd0);
    check32("flush_ready", 32'(bus.op_ready), 32'd1);
    @(posedge clk);
    #1;
    // flush while idle blocks acceptance
    bus.flush    = 1'b1;
    bus.op_valid = 1'b1;
    bus.op_ctr   = MD_MTLO;
    bus.op_a     = 32'hDEAD;
    @(negedge clk);
    check32("flush_idle_ready", 32'(bus.op_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    @(negedge clk);
    check32("flush_idle_lo", bus.lo, m_lo);
    @(posedge clk);
    #1;
    issue(MD_MTLO, 32'h1234, 32'd0, 1'b1);
    wait_idle();

    // reset in cycle 2 of a multi-cycle op
`ifdef MD_FAST_MUL_EN
    issue(MD_DIV, 32'd3, 32'd4, 1'b0);
`else
    issue(MD_MUL, 32'd3, 32'd4, 1'b0);
`endif
    exp_q.push_back({32'd0, 32'd0, 8'd1});
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check32("arst_busy", 32'(bus.busy), 32'd0);
    check32("arst_hi", bus.hi, 32'd0);
    check32("arst_lo", bus.lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // randomized operations, some back-to-back
    for (int i = 0; i < 40; i++) begin
      ctr = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      bus.rd_req = 1'($urandom_range(0, 1));
      bus.rd_sel = 1'($urandom_range(0, 1));
      issue(ctr, a, b, 1'b1);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);
    check32("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
